// File: rtl/blackbox_seq_pkg.sv
// rtl/blackbox_seq_pkg.sv - shared types for the black-box check sequencer
package blackbox_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        INVERT   = 2'd0,
        PASS     = 2'd1,
        REGISTER = 2'd2,
        CONSTANT = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/blackbox_expect_model.sv
// rtl/blackbox_expect_model.sv - reference model of the selected 1-bit DUT flavour
module blackbox_expect_model
    import blackbox_seq_pkg::*;
#(
    parameter logic CONST_VALUE = 1'b1
) (
    input  logic  clock,
    input  logic  reset,
    input  mode_e mode,
    input  logic  stimulus,
    output logic  expected
);

    logic prev_q;

    // Delay flop runs every cycle so DRAIN sees the last RUN stimulus.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= stimulus;
        end
    end

    always_comb begin
        expected = CONST_VALUE;
        case (mode)
            INVERT:   expected = ~stimulus;
            PASS:     expected = stimulus;
            REGISTER: expected = prev_q;
            default:  expected = CONST_VALUE;
        endcase
    end

endmodule

// File: rtl/blackbox_check_sequencer.sv
// rtl/blackbox_check_sequencer.sv - drives a fixed pattern into a 1-bit DUT and checks it; BLACKBOX_SEQ_STOP_ON_FAIL_EN ends a run at the first mismatch
module blackbox_check_sequencer
    import blackbox_seq_pkg::*;
#(
    parameter int                     NUM_VECTORS = 8,
    parameter logic [NUM_VECTORS-1:0] PATTERN     = 8'hB2,
    parameter logic                   CONST_VALUE = 1'b1,
    localparam int                    CW          = $clog2(NUM_VECTORS + 1),
    localparam int                    IW          = $clog2(NUM_VECTORS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    output logic              dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CW-1:0]     err_count,
    output logic [IW-1:0]     fail_index
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VECTORS - 1);

    state_e        state_q, state_d;
    mode_e         mode_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] vec;
    logic          cmp_en;
    logic          expected;
    logic          mismatch;
    logic [CW-1:0] err_d;

    blackbox_expect_model #(
        .CONST_VALUE (CONST_VALUE)
    ) u_model (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode_q),
        .stimulus (dut_in),
        .expected (expected)
    );

    always_comb begin
        dut_in = 1'b0;
        if (state_q == RUN && mode_q != CONSTANT) begin
            dut_in = PATTERN[idx_q];
        end
    end

    // REGISTER mode checks one cycle late: skip idx 0, add the DRAIN cycle.
    always_comb begin
        cmp_en = 1'b0;
        vec    = idx_q;
        if (state_q == RUN) begin
            if (mode_q == REGISTER) begin
                cmp_en = (idx_q != '0);
                vec    = idx_q - 1'b1;
            end else begin
                cmp_en = 1'b1;
            end
        end else if (state_q == DRAIN && mode_q == REGISTER) begin
            cmp_en = 1'b1;
            vec    = LAST_IDX;
        end
    end

    assign mismatch = cmp_en && (dut_out != expected);
    assign err_d    = err_count + CW'(mismatch);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                if (idx_q == LAST_IDX) state_d = DRAIN;
`ifdef BLACKBOX_SEQ_STOP_ON_FAIL_EN
                if (mismatch) state_d = DONE;
`endif
            end
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= INVERT;
            idx_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN) || (state_d == DRAIN);
            done    <= (state_d == DONE);
            if (state_q == IDLE && start) begin
                mode_q     <= mode_e'(mode);
                idx_q      <= '0;
                err_count  <= '0;
                fail_index <= '0;
                pass       <= 1'b0;
            end else begin
                if (state_q == RUN) idx_q <= idx_q + 1'b1;
                if (mismatch) begin
                    err_count <= err_d;
                    if (err_count == '0) fail_index <= vec;
                end
                if (state_d == DONE) pass <= (err_d == '0);
            end
        end
    end

endmodule
